// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports, two writeback
// ports with write-through bypass, special zero/PC/flag entries, load scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NREAD    = 2,
    parameter int ZERO_IDX = 0,
    parameter int PC_IDX   = 15,
    parameter int T_IDX    = 8
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NREAD*ADDR_W-1:0] RdAddr,
    output logic [NREAD*DATA_W-1:0] RdData,
    output logic [NREAD-1:0]        RdBusy,
    input  logic [DATA_W-1:0]       PcAddr,
    input  logic                    We0,
    input  logic [ADDR_W-1:0]       WAddr0,
    input  logic [DATA_W-1:0]       WData0,
    input  logic                    We1,
    input  logic [ADDR_W-1:0]       WAddr1,
    input  logic [DATA_W-1:0]       WData1,
    input  logic                    SbSet,
    input  logic [ADDR_W-1:0]       SbAddr,
    output logic                    AnyBusy,
    output logic [DATA_W-1:0]       RegPeek
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] T_A    = ADDR_W'(T_IDX);
    localparam logic [ADDR_W-1:0] PEEK_A = ADDR_W'(6);

    function automatic logic [DATA_W-1:0] commit_val(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        if (addr == T_A) begin
            return {{(DATA_W-1){1'b0}}, (data == '0)};
        end
        return data;
    endfunction

    function automatic logic is_special(input logic [ADDR_W-1:0] addr);
        return (addr == ZERO_A) || (addr == PC_A);
    endfunction

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   sb_q;
    logic [NREG-1:0]   sb_d;
    logic [NREG-1:0]   sb_clr;
    logic [NREG-1:0]   sb_set;
    logic [DATA_W-1:0] peek_q;
    logic [DATA_W-1:0] peek_d;
    logic [DATA_W-1:0] wval0;
    logic [DATA_W-1:0] wval1;
    logic              wr0;
    logic              wr1;

    always_comb begin
        wval0 = commit_val(WAddr0, WData0);
        wval1 = commit_val(WAddr1, WData1);
        wr0   = We0 && !is_special(WAddr0);
        wr1   = We1 && !is_special(WAddr1);
    end

    // WB1 is applied last so it overrides WB0 on a shared index
    always_comb begin
        regs_d = regs_q;
        if (wr0) regs_d[WAddr0] = wval0;
        if (wr1) regs_d[WAddr1] = wval1;
        peek_d = regs_d[PEEK_A];
    end

    always_comb begin
        sb_clr = NREG'(We1) << WAddr1;
        sb_set = NREG'(SbSet && !is_special(SbAddr)) << SbAddr;
        sb_d   = (sb_q & ~sb_clr) | sb_set;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            sb_q   <= '0;
            peek_q <= '0;
        end else begin
            regs_q <= regs_d;
            sb_q   <= sb_d;
            peek_q <= peek_d;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] lane;
        RdData = '0;
        RdBusy = '0;
        ra     = '0;
        lane   = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = RdAddr[k*ADDR_W +: ADDR_W];
            if (ra == ZERO_A) begin
                lane = '0;
            end else if (ra == PC_A) begin
                lane = PcAddr;
            end else if (We1 && (WAddr1 == ra)) begin
                lane = wval1;
            end else if (We0 && (WAddr0 == ra)) begin
                lane = wval0;
            end else begin
                lane = regs_q[ra];
            end
            RdData[k*DATA_W +: DATA_W] = lane;
            RdBusy[k] = !is_special(ra) && sb_q[ra]
                        && !(We1 && (WAddr1 == ra));
        end
    end

    assign AnyBusy = |sb_q;
    assign RegPeek = peek_q;

endmodule
